// File: rtl/lutram_mw_mr_pkg.sv
// Shared constants and sizing helpers for the multi-port LUTRAM block.
// No state, no types; widths are derived by each user from its own parameters.
package lutram_mw_mr_pkg;

   localparam int MAX_PORTS = 4;

   // Live-value-table entry width: one bit minimum so the table stays addressable.
   function automatic int lvt_width(input int num_write);
      return (num_write > 1) ? $clog2(num_write) : 1;
   endfunction

endpackage

// File: rtl/lutram_mw_mr_if.sv
// Write/read port bundle for lutram_mw_mr; master drives addresses and write data, slave returns read data.
// Purely combinational wiring: no handshake, every write is taken on the edge it is presented.
interface lutram_mw_mr_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_WRITE = 2,
   parameter int NUM_READ  = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_WRITE-1:0][AW-1:0]    waddr;
   logic [NUM_WRITE-1:0]            wen;
   logic [NUM_WRITE-1:0][WIDTH-1:0] wdata;
   logic [NUM_READ-1:0][AW-1:0]     raddr;
   logic [NUM_READ-1:0][WIDTH-1:0]  rdata;

   modport master (
      output waddr,
      output wen,
      output wdata,
      output raddr,
      input  rdata
   );

   modport slave (
      input  waddr,
      input  wen,
      input  wdata,
      input  raddr,
      output rdata
   );

endinterface

// File: rtl/lutram_1w_1r.sv
// One-write one-read distributed RAM bank: write on rising edge, asynchronous read (0-cycle latency).
// No backpressure; contents are not reset here, the owner clears them.
module lutram_1w_1r #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lutram_mw_mr.sv
// Multi-write multi-read LUTRAM from 1w1r banks plus live-value table; reads 0 cycles, writes visible 1 edge later.
// No backpressure: writes ignored during the post-reset clearing sweep, rdata held at zero until init_done.
module lutram_mw_mr
   import lutram_mw_mr_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_WRITE = 2,
   parameter int NUM_READ  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          init_done,
   lutram_mw_mr_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvt_width(NUM_WRITE);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("lutram_mw_mr: DEPTH must be a power of two >= 2");
      end
      if ((NUM_WRITE < 1) || (NUM_WRITE > MAX_PORTS)) begin : g_bad_nw
         $error("lutram_mw_mr: NUM_WRITE must be 1..4");
      end
      if ((NUM_READ < 1) || (NUM_READ > MAX_PORTS)) begin : g_bad_nr
         $error("lutram_mw_mr: NUM_READ must be 1..4");
      end
   endgenerate

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            clr_we;
   logic [NUM_WRITE-1:0] run_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign init_done = (state_q == RUN);

   // Reset cycles must not clear: zeroing only happens on edges with rst_n high.
   assign clr_we = (state_q == CLEAR) && rst_n;

   logic [WIDTH-1:0] bank_rd [NUM_WRITE][NUM_READ];

   generate
      for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wport
         logic [AW-1:0]    wa;
         logic [WIDTH-1:0] wd;
         logic             we;

         assign run_we[w] = (state_q == RUN) && rst_n && bus.wen[w];
         assign we        = clr_we | run_we[w];
         assign wa        = clr_we ? cnt_q : bus.waddr[w];
         assign wd        = clr_we ? '0 : bus.wdata[w];

         for (genvar r = 0; r < NUM_READ; r++) begin : g_rport
            lutram_1w_1r #(
               .WIDTH(WIDTH),
               .DEPTH(DEPTH)
            ) u_bank (
               .clk   (clk),
               .we    (we),
               .waddr (wa),
               .wdata (wd),
               .raddr (bus.raddr[r]),
               .rdata (bank_rd[w][r])
            );
         end
      end
   endgenerate

   logic [LW-1:0] rsel [NUM_READ];

   generate
      if (NUM_WRITE > 1) begin : g_lvt
         logic [LW-1:0] lvt_q [DEPTH];

         // Ascending loop: a later (higher) port overwrites a lower one on the same address.
         always_ff @(posedge clk) begin
            if (clr_we) begin
               lvt_q[cnt_q] <= '0;
            end else begin
               for (int w = 0; w < NUM_WRITE; w++) begin
                  if (run_we[w]) begin
                     lvt_q[bus.waddr[w]] <= LW'(w);
                  end
               end
            end
         end

         for (genvar r = 0; r < NUM_READ; r++) begin : g_sel
            assign rsel[r] = lvt_q[bus.raddr[r]];
         end
      end else begin : g_no_lvt
         for (genvar r = 0; r < NUM_READ; r++) begin : g_sel
            assign rsel[r] = '0;
         end
      end
   endgenerate

   logic [NUM_READ-1:0][WIDTH-1:0] rdata_c;

   always_comb begin
      rdata_c = '0;
      for (int r = 0; r < NUM_READ; r++) begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (init_done && (rsel[r] == LW'(w))) begin
               rdata_c[r] = bank_rd[w][r];
            end
         end
      end
   end

   assign bus.rdata = rdata_c;

endmodule
